// File: rtl/lc_transition_arbiter.sv
// Round-robin arbiter that shares one lifecycle transition port among NUM_REQ requesters,
// with an engine timeout, a consecutive-failure lockout and end-of-life request rejection.
`ifndef LC_MEMORY_WIDTH
`define LC_MEMORY_WIDTH 8
`endif

module lc_transition_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_WIDTH       = `LC_MEMORY_WIDTH,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MAX_FAILS      = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ID_WIDTH-1:0] req_id,
    output logic [NUM_REQ-1:0]          req_ack,
    output logic                        req_success,
    output logic                        lc_transition_request,
    output logic [ID_WIDTH-1:0]         lc_identifier,
    input  logic                        lc_done,
    input  logic                        lc_success,
    input  logic [2:0]                  lc_state,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_idx,
    output logic                        locked,
    output logic                        timeout_err
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FW = $clog2(MAX_FAILS + 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_DONE = 2'd1;
    localparam logic [1:0] RELEASE   = 2'd2;
    localparam logic [1:0] LOCKED    = 2'd3;

    localparam logic [2:0]    LC_EOL   = 3'b101;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAILS);
    localparam logic [GW-1:0] LAST_IDX = GW'(NUM_REQ - 1);

    logic [1:0]    r_state;
    logic [GW-1:0] r_last;
    logic [TW-1:0] r_tmo_cnt;
    logic [FW-1:0] r_fail_cnt;

    logic          w_any;
    logic [GW-1:0] w_sel;
    logic          w_reject;
    logic [FW-1:0] w_fail_inc;

    // First asserted requester scanning upward from the one after the last grant.
    always_comb begin : rr_select
        int idx;
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_any = 1'b0;
        w_sel = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(r_last) + 1 + k) % NUM_REQ;
            if (!w_any && req_valid[idx[GW-1:0]]) begin
                w_any = 1'b1;
                w_sel = idx[GW-1:0];
            end
        end
    end

    assign w_reject   = (r_state == LOCKED) || ((r_state == IDLE) && (lc_state == LC_EOL));
    assign w_fail_inc = (r_fail_cnt == FAIL_MAX) ? r_fail_cnt : r_fail_cnt + 1'b1;
    assign busy       = (r_state == WAIT_DONE) || (r_state == RELEASE);
    assign locked     = (r_state == LOCKED);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state               <= IDLE;
            r_last                <= LAST_IDX;
            r_tmo_cnt             <= '0;
            r_fail_cnt            <= '0;
            lc_transition_request <= 1'b0;
            lc_identifier         <= '0;
            grant_idx             <= '0;
            req_ack               <= '0;
            req_success           <= 1'b0;
            timeout_err           <= 1'b0;
        end else begin
            req_ack     <= '0;
            req_success <= 1'b0;
            timeout_err <= 1'b0;
            case (r_state)
                IDLE, LOCKED: begin
                    if (w_reject) begin
                        // Refused requests get a failing ack; skipping the ack cycle paces one per two cycles.
                        if (w_any && (req_ack == '0)) begin
                            req_ack[w_sel] <= 1'b1;
                            r_last         <= w_sel;
                        end
                    end else if (w_any) begin
                        r_state               <= WAIT_DONE;
                        grant_idx             <= w_sel;
                        r_last                <= w_sel;
                        lc_identifier         <= req_id[w_sel*ID_WIDTH +: ID_WIDTH];
                        lc_transition_request <= 1'b1;
                        r_tmo_cnt             <= '0;
                    end
                end
                WAIT_DONE: begin
                    // Engine completion takes precedence over a coincident timeout.
                    if (lc_done) begin
                        lc_transition_request <= 1'b0;
                        req_ack[grant_idx]    <= 1'b1;
                        req_success           <= lc_success;
                        r_fail_cnt            <= lc_success ? '0 : w_fail_inc;
                        r_state               <= RELEASE;
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        lc_transition_request <= 1'b0;
                        req_ack[grant_idx]    <= 1'b1;
                        timeout_err           <= 1'b1;
                        r_fail_cnt            <= w_fail_inc;
                        r_state               <= RELEASE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!lc_done) begin
                        r_state <= (r_fail_cnt == FAIL_MAX) ? LOCKED : IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lc_transition_arbiter.sv
// Directed bench for lc_transition_arbiter: single request, contention, timeout,
// done/timeout collision, lockout, end-of-life rejection and asynchronous reset.
module tb_lc_transition_arbiter;

    localparam int N  = 4;
    localparam int IW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*IW-1:0] req_id;
    logic [N-1:0]    req_ack;
    logic            req_success;
    logic            lc_transition_request;
    logic [IW-1:0]   lc_identifier;
    logic            lc_done = 1'b0;
    logic            lc_success = 1'b0;
    logic [2:0]      lc_state = 3'b000;
    logic            busy;
    logic [1:0]      grant_idx;
    logic            locked;
    logic            timeout_err;

    logic [IW-1:0] ids [N];
    int n_cmp = 0;
    int n_mis = 0;

    assign ids[0] = 8'hA0;
    assign ids[1] = 8'hB1;
    assign ids[2] = 8'hC2;
    assign ids[3] = 8'hD3;
    assign req_id = {ids[3], ids[2], ids[1], ids[0]};

    always #5 clk = ~clk;

    lc_transition_arbiter #(
        .NUM_REQ(N), .ID_WIDTH(IW), .TIMEOUT_CYCLES(64), .MAX_FAILS(3)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_id(req_id),
        .req_ack(req_ack), .req_success(req_success),
        .lc_transition_request(lc_transition_request), .lc_identifier(lc_identifier),
        .lc_done(lc_done), .lc_success(lc_success), .lc_state(lc_state),
        .busy(busy), .grant_idx(grant_idx), .locked(locked), .timeout_err(timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req_valid  = '0;
        lc_done    = 1'b0;
        lc_success = 1'b0;
        lc_state   = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Waits for a grant, checks it, completes it with the given result and checks ack/release.
    task automatic serve(input int exp, input logic succ);
        logic [N-1:0] e_ack;
        e_ack = '0;
        e_ack[exp] = 1'b1;
        for (int i = 0; i < 10 && !lc_transition_request; i++) tick();
        n_cmp++;
        if (lc_transition_request !== 1'b1) begin
            n_mis++;
            $display("FAIL serve_wait_req: got %b want 1 (requester %0d)", lc_transition_request, exp);
            return;
        end
        n_cmp++;
        if (grant_idx !== 2'(exp)) begin
            n_mis++; $display("FAIL serve_grant_idx: got %0d want %0d", grant_idx, exp);
        end
        n_cmp++;
        if (lc_identifier !== ids[exp]) begin
            n_mis++; $display("FAIL serve_identifier: got %h want %h", lc_identifier, ids[exp]);
        end
        lc_done = 1'b1;
        lc_success = succ;
        tick();
        n_cmp++;
        if ({req_ack, req_success, lc_transition_request} !== {e_ack, succ, 1'b0}) begin
            n_mis++;
            $display("FAIL serve_ack: got ack=%b succ=%b req=%b want ack=%b succ=%b req=0",
                     req_ack, req_success, lc_transition_request, e_ack, succ);
        end
        lc_done = 1'b0;
        lc_success = 1'b0;
        tick();
        n_cmp++;
        if ({req_ack, lc_transition_request} !== {4'b0000, 1'b0}) begin
            n_mis++;
            $display("FAIL serve_release: got ack=%b req=%b want ack=0000 req=0", req_ack, lc_transition_request);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({lc_transition_request, req_ack, req_success, busy, locked, timeout_err} !== 9'b0) begin
            n_mis++;
            $display("FAIL reset_flags: got req=%b ack=%b succ=%b busy=%b locked=%b tmo=%b want all 0",
                     lc_transition_request, req_ack, req_success, busy, locked, timeout_err);
        end
        n_cmp++;
        if ({grant_idx, lc_identifier} !== 10'b0) begin
            n_mis++; $display("FAIL reset_regs: got grant=%0d id=%h want 0/00", grant_idx, lc_identifier);
        end
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0100;
        tick();
        n_cmp++;
        if ({lc_transition_request, busy, grant_idx, lc_identifier} !== {1'b1, 1'b1, 2'd2, 8'hC2}) begin
            n_mis++;
            $display("FAIL single_grant: got req=%b busy=%b grant=%0d id=%h want 1/1/2/c2",
                     lc_transition_request, busy, grant_idx, lc_identifier);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            n_cmp++;
            if ({lc_transition_request, req_ack} !== {1'b1, 4'b0000}) begin
                n_mis++;
                $display("FAIL single_hold: got req=%b ack=%b want req=1 ack=0000", lc_transition_request, req_ack);
            end
        end
        lc_done = 1'b1;
        lc_success = 1'b1;
        tick();
        n_cmp++;
        if ({lc_transition_request, req_ack, req_success, timeout_err} !== {1'b0, 4'b0100, 1'b1, 1'b0}) begin
            n_mis++;
            $display("FAIL single_done: got req=%b ack=%b succ=%b tmo=%b want 0/0100/1/0",
                     lc_transition_request, req_ack, req_success, timeout_err);
        end
        lc_done = 1'b0;
        lc_success = 1'b0;
        req_valid = '0;
        tick();
        n_cmp++;
        if ({req_ack, busy, lc_identifier, grant_idx} !== {4'b0000, 1'b0, 8'hC2, 2'd2}) begin
            n_mis++;
            $display("FAIL single_after: got ack=%b busy=%b id=%h grant=%0d want 0000/0/c2/2",
                     req_ack, busy, lc_identifier, grant_idx);
        end
    endtask

    task automatic test_contention();
        do_reset();
        req_valid = 4'b1111;
        serve(0, 1'b1);
        serve(1, 1'b1);
        serve(2, 1'b1);
        serve(3, 1'b1);
        serve(0, 1'b1);
        req_valid = '0;
    endtask

    task automatic test_timeout();
        int cnt;
        do_reset();
        req_valid = 4'b0001;
        tick();
        cnt = 0;
        while (lc_transition_request && cnt < 200) begin
            cnt++;
            tick();
        end
        n_cmp++;
        if (cnt !== 64) begin
            n_mis++; $display("FAIL timeout_len: got %0d cycles want 64", cnt);
        end
        n_cmp++;
        if ({timeout_err, req_ack, req_success} !== {1'b1, 4'b0001, 1'b0}) begin
            n_mis++;
            $display("FAIL timeout_abort: got tmo=%b ack=%b succ=%b want 1/0001/0", timeout_err, req_ack, req_success);
        end
        req_valid = '0;
        tick();
        n_cmp++;
        if ({timeout_err, req_ack} !== 5'b0) begin
            n_mis++; $display("FAIL timeout_pulse: got tmo=%b ack=%b want 0/0000", timeout_err, req_ack);
        end
    endtask

    task automatic test_done_vs_timeout();
        do_reset();
        req_valid = 4'b0010;
        tick();
        repeat (63) tick();
        n_cmp++;
        if (lc_transition_request !== 1'b1) begin
            n_mis++; $display("FAIL collide_pending: got req=%b want 1", lc_transition_request);
        end
        lc_done = 1'b1;
        lc_success = 1'b1;
        tick();
        n_cmp++;
        if ({req_ack, req_success, timeout_err} !== {4'b0010, 1'b1, 1'b0}) begin
            n_mis++;
            $display("FAIL collide_result: got ack=%b succ=%b tmo=%b want 0010/1/0", req_ack, req_success, timeout_err);
        end
        lc_done = 1'b0;
        lc_success = 1'b0;
        req_valid = '0;
        tick();
    endtask

    task automatic test_lockout();
        do_reset();
        req_valid = 4'b1111;
        serve(0, 1'b0);
        serve(1, 1'b0);
        serve(2, 1'b0);
        req_valid = '0;
        n_cmp++;
        if ({locked, busy} !== 2'b10) begin
            n_mis++; $display("FAIL lock_enter: got locked=%b busy=%b want 1/0", locked, busy);
        end
        tick();
        req_valid = 4'b0100;
        tick();
        n_cmp++;
        if ({req_ack, req_success, lc_transition_request, locked} !== {4'b0100, 1'b0, 1'b0, 1'b1}) begin
            n_mis++;
            $display("FAIL lock_reject: got ack=%b succ=%b req=%b locked=%b want 0100/0/0/1",
                     req_ack, req_success, lc_transition_request, locked);
        end
        tick();
        n_cmp++;
        if (req_ack !== 4'b0000) begin
            n_mis++; $display("FAIL lock_pacing: got ack=%b want 0000", req_ack);
        end
        tick();
        n_cmp++;
        if (req_ack !== 4'b0100) begin
            n_mis++; $display("FAIL lock_reack: got ack=%b want 0100", req_ack);
        end
        req_valid = '0;
        repeat (5) tick();
        n_cmp++;
        if ({locked, lc_transition_request} !== 2'b10) begin
            n_mis++; $display("FAIL lock_persist: got locked=%b req=%b want 1/0", locked, lc_transition_request);
        end
        do_reset();
        n_cmp++;
        if (locked !== 1'b0) begin
            n_mis++; $display("FAIL lock_cleared: got locked=%b want 0", locked);
        end
    endtask

    task automatic test_eol();
        do_reset();
        lc_state = 3'b101;
        req_valid = 4'b0001;
        tick();
        n_cmp++;
        if ({req_ack, req_success, lc_transition_request, busy} !== {4'b0001, 1'b0, 1'b0, 1'b0}) begin
            n_mis++;
            $display("FAIL eol_reject: got ack=%b succ=%b req=%b busy=%b want 0001/0/0/0",
                     req_ack, req_success, lc_transition_request, busy);
        end
        req_valid = '0;
        tick();
        n_cmp++;
        if ({req_ack, locked, lc_transition_request} !== 6'b0) begin
            n_mis++;
            $display("FAIL eol_after: got ack=%b locked=%b req=%b want 0000/0/0", req_ack, locked, lc_transition_request);
        end
        lc_state = 3'b000;
        req_valid = 4'b0001;
        serve(0, 1'b1);
        req_valid = '0;
    endtask

    task automatic test_async_reset();
        do_reset();
        req_valid = 4'b0010;
        tick();
        n_cmp++;
        if ({lc_transition_request, grant_idx} !== {1'b1, 2'd1}) begin
            n_mis++; $display("FAIL areset_setup: got req=%b grant=%0d want 1/1", lc_transition_request, grant_idx);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({lc_transition_request, req_ack, req_success, busy, locked, timeout_err, grant_idx, lc_identifier} !== 19'b0) begin
            n_mis++;
            $display("FAIL areset_immediate: got req=%b ack=%b succ=%b busy=%b locked=%b tmo=%b grant=%0d id=%h want all 0",
                     lc_transition_request, req_ack, req_success, busy, locked, timeout_err, grant_idx, lc_identifier);
        end
        lc_done = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (req_ack !== 4'b0000) begin
            n_mis++; $display("FAIL areset_no_ack: got ack=%b want 0000", req_ack);
        end
        lc_done = 1'b0;
        rst_n = 1'b1;
        req_valid = 4'b1111;
        serve(0, 1'b1);
        req_valid = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_timeout();
        test_done_vs_timeout();
        test_lockout();
        test_eol();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
